uart_reg_host: RTL and testbench

- Register-bus initiator that drives the 8-bit reg bus of a uart_core instance (reg_cs/reg_wr/reg_addr/reg_wdata/reg_be, reg_rdata/reg_ack).
- Converts two local byte streams into UART register accesses:
  - TX stream (valid/ready) → writes to the UART TX data register.
  - RX data register → RX stream (valid/ready).
- Polls the UART status register to avoid writing a full TX FIFO or reading an empty RX FIFO.
- Sits between a local byte client (debug monitor, boot loader) and the UART.

---
 rtl/uart_reg_host.sv | 209 ++++++++++++++++++++
 tb/tb_uart_reg_host.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_host.sv
// Polls a uart_core status register and moves bytes between local TX/RX streams and its data registers.
// One bus access in flight at a time; streams stall via tx_ready/rx_valid; an unacked access times out.
module uart_reg_host #(
  parameter logic [3:0] STS_ADDR    = 4'h1,
  parameter logic [3:0] TXD_ADDR    = 4'h2,
  parameter logic [3:0] RXD_ADDR    = 4'h3,
  parameter int         TXFULL_BIT  = 0,
  parameter int         RXEMPTY_BIT = 1,
  parameter int         TMO_W       = 8
) (
  input  logic       app_clk,
  input  logic       arst,
  input  logic       cfg_enable,
  input  logic [7:0] cfg_poll_gap,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       reg_cs,
  output logic       reg_wr,
  output logic [3:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_be,
  input  logic [7:0] reg_rdata,
  input  logic       reg_ack,
  output logic       tmo_err,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, STS_RD, DECIDE, TX_WR, RX_RD, GAP} state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
  localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             out_en_q, out_en_d;
  logic             hold_valid_q, hold_valid_d;
  logic [7:0]       hold_data_q, hold_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             cs_q, cs_d;
  logic             wr_q, wr_d;
  logic [3:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       sts_q, sts_d;
  logic             rr_pri_q, rr_pri_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       gap_q, gap_d;
  logic             tmo_err_q, tmo_err_d;

  logic ack_v, tmo_hit, tx_ok, rx_ok;

  // tx_ready is held low through reset and the first edge after it
  assign tx_ready  = out_en_q & ~hold_valid_q;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign reg_cs    = cs_q;
  assign reg_wr    = wr_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_be    = cs_q;
  assign tmo_err   = tmo_err_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    out_en_d     = 1'b1;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    rx_valid_d   = rx_valid_q;
    rx_data_d    = rx_data_q;
    cs_d         = cs_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    sts_d        = sts_q;
    rr_pri_d     = rr_pri_q;
    gap_d        = gap_q;
    tmo_err_d    = 1'b0;
    tmo_d        = '0;

    ack_v   = reg_ack & cs_q;
    tmo_hit = cs_q & ~reg_ack & (tmo_q == TMO_LAST);
    tx_ok   = hold_valid_q & ~sts_q[TXFULL_BIT];
    rx_ok   = ~sts_q[RXEMPTY_BIT] & ~rx_valid_q;

    if (tx_valid && tx_ready) begin
      hold_valid_d = 1'b1;
      hold_data_d  = tx_data;
    end
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cfg_enable) begin
          cs_d    = 1'b1;
          wr_d    = 1'b0;
          addr_d  = STS_ADDR;
          wdata_d = 8'h00;
          state_d = STS_RD;
        end
      end
      STS_RD: begin
        if (ack_v) begin
          sts_d   = reg_rdata;
          cs_d    = 1'b0;
          state_d = DECIDE;
        end
      end
      DECIDE: begin
        if (!cfg_enable) begin
          state_d = IDLE;
        end else if (tx_ok && (!rx_ok || !rr_pri_q)) begin
          cs_d    = 1'b1;
          wr_d    = 1'b1;
          addr_d  = TXD_ADDR;
          wdata_d = hold_data_q;
          state_d = TX_WR;
          if (rx_ok) rr_pri_d = ~rr_pri_q;
        end else if (rx_ok) begin
          cs_d    = 1'b1;
          wr_d    = 1'b0;
          addr_d  = RXD_ADDR;
          wdata_d = 8'h00;
          state_d = RX_RD;
          if (tx_ok) rr_pri_d = ~rr_pri_q;
        end else begin
          gap_d   = 8'h00;
          state_d = GAP;
        end
      end
      TX_WR: begin
        if (ack_v) begin
          hold_valid_d = 1'b0;
          cs_d         = 1'b0;
          state_d      = IDLE;
        end
      end
      RX_RD: begin
        if (ack_v) begin
          rx_valid_d = 1'b1;
          rx_data_d  = reg_rdata;
          cs_d       = 1'b0;
          state_d    = IDLE;
        end
      end
      GAP: begin
        // a zero gap still spends one cycle here
        if (({1'b0, gap_q} + 9'd1) >= {1'b0, cfg_poll_gap}) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (tmo_hit) begin
      cs_d      = 1'b0;
      tmo_err_d = 1'b1;
      state_d   = IDLE;
    end

    if (cs_q && cs_d) begin
      tmo_d = tmo_q + TMO_ONE;
    end
  end

  always_ff @(posedge app_clk or posedge arst) begin
    if (arst) begin
      state_q      <= IDLE;
      out_en_q     <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= 8'h00;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= 8'h00;
      cs_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= 4'h0;
      wdata_q      <= 8'h00;
      sts_q        <= 8'h00;
      rr_pri_q     <= 1'b0;
      tmo_q        <= '0;
      gap_q        <= 8'h00;
      tmo_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_en_q     <= out_en_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_data_q    <= rx_data_d;
      cs_q         <= cs_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      sts_q        <= sts_d;
      rr_pri_q     <= rr_pri_d;
      tmo_q        <= tmo_d;
      gap_q        <= gap_d;
      tmo_err_q    <= tmo_err_d;
    end
  end

endmodule

// File: tb/tb_uart_reg_host.sv
// Bench for uart_reg_host: directed scenarios with a scripted responder, then a random phase
// against a queue-based UART model (bounded TX FIFO, random RX arrivals).
module tb_uart_reg_host;

  logic       app_clk = 1'b0;
  logic       arst;
  logic       cfg_enable;
  logic [7:0] cfg_poll_gap;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       reg_cs, reg_wr, reg_be;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata = 8'h00;
  logic       reg_ack = 1'b0;
  logic       tmo_err, busy;

  always #5 app_clk = ~app_clk;

  uart_reg_host dut (
    .app_clk(app_clk), .arst(arst), .cfg_enable(cfg_enable), .cfg_poll_gap(cfg_poll_gap),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_be(reg_be), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
    .tmo_err(tmo_err), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- responder / UART model (sole owner of its state) ----------------
  typedef struct {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    bit         acked;
    int         len;
    int         gap;
  } acc_t;

  acc_t       bus_log[$];
  logic [7:0] txq[$], rxq[$], mtx_log[$], rxgen_log[$];
  acc_t       cur;
  bit         in_acc = 0;
  int         low_cnt = 0, cur_dly = 0, stab_err = 0, model_err = 0, tmo_cnt = 0, rx_gen = 0;
  logic [7:0] rb, rdat;

  // configuration written by the main sequence only
  bit         mode = 0, no_ack = 0;
  int         ack_dly = 1, rx_target = 0;
  logic [7:0] sts_val = 8'h02, rxd_val = 8'h00;

  always @(negedge app_clk) begin
    reg_ack = 1'b0;
    if (tmo_err) tmo_cnt++;
    if (mode) begin
      if (txq.size() > 0 && $urandom_range(0, 3) == 0) txq.delete(0);
      if (rx_gen < rx_target && $urandom_range(0, 5) == 0) begin
        rb = 8'($urandom);
        rxq.push_back(rb);
        rxgen_log.push_back(rb);
        rx_gen++;
      end
    end
    if (reg_cs) begin
      if (!in_acc) begin
        in_acc    = 1;
        cur.wr    = reg_wr;
        cur.addr  = reg_addr;
        cur.wdata = reg_wdata;
        cur.rdata = 8'h00;
        cur.acked = 0;
        cur.len   = 0;
        cur.gap   = low_cnt;
        cur_dly   = mode ? int'($urandom_range(0, 3)) : ack_dly;
        low_cnt   = 0;
      end else if (reg_wr !== cur.wr || reg_addr !== cur.addr || reg_wdata !== cur.wdata) begin
        stab_err++;
      end
      if (reg_be !== 1'b1) stab_err++;
      cur.len++;
      if (!no_ack && cur.len > cur_dly) begin
        rdat = 8'h00;
        if (!cur.wr && cur.addr == 4'h1) begin
          rdat = mode ? {6'd0, rxq.size() == 0, txq.size() >= 4} : sts_val;
        end else if (!cur.wr && cur.addr == 4'h3) begin
          if (!mode) rdat = rxd_val;
          else if (rxq.size() == 0) model_err++;
          else rdat = rxq.pop_front();
        end else if (cur.wr && cur.addr == 4'h2 && mode) begin
          if (txq.size() >= 4) model_err++;
          else txq.push_back(cur.wdata);
          mtx_log.push_back(cur.wdata);
        end
        reg_rdata = rdat;
        reg_ack   = 1'b1;
        cur.rdata = rdat;
        cur.acked = 1;
        bus_log.push_back(cur);
        in_acc = 0;
      end
    end else begin
      if (in_acc) begin
        bus_log.push_back(cur);
        in_acc = 0;
      end
      low_cnt++;
    end
  end

  // ---------------- main sequence ----------------
  int         rd_ptr = 0;
  logic [7:0] s_log[$], got_log[$];
  int         rx_unstable = 0;

  task automatic next_acc(input string tag, output acc_t a);
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (bus_log.size() > rd_ptr) begin
        ok = 1;
        break;
      end
      @(negedge app_clk);
    end
    a = '{default: 0};
    if (ok) begin
      a = bus_log[rd_ptr];
      rd_ptr++;
    end else begin
      chk(tag, 0, 1);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    tx_valid = 1'b1;
    tx_data  = b;
    while (!tx_ready && n < 3000) begin
      @(negedge app_clk);
      n++;
    end
    if (!tx_ready) chk("send_wait", 0, 1);
    else s_log.push_back(b);
    @(negedge app_clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge app_clk);
      n++;
    end
    chk("idle_wait", busy, 0);
  endtask

  acc_t       a;
  bit         found;
  int         t0, n, exp_pri;
  bit         held;
  logic [7:0] pd, rbyte;

  initial begin
    arst = 1'b1; cfg_enable = 1'b0; cfg_poll_gap = 8'd0;
    tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;

    // reset values
    repeat (3) @(negedge app_clk);
    chk("rst_cs", reg_cs, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tmo", tmo_err, 0);
    chk("rst_be", reg_be, 0);
    arst = 1'b0;
    @(negedge app_clk);
    chk("post_rst_tx_ready", tx_ready, 1);

    // TX path
    sts_val = 8'h02; ack_dly = 1;
    send_byte(8'h5A);
    chk("hold_full", tx_ready, 0);
    rd_ptr = bus_log.size();
    cfg_enable = 1'b1;
    next_acc("tx_sts", a);
    chk("tx_sts_addr", {a.wr, a.addr}, {1'b0, 4'h1});
    next_acc("tx_wr", a);
    chk("tx_wr_addr", {a.wr, a.addr}, {1'b1, 4'h2});
    chk("tx_wr_data", a.wdata, 8'h5A);
    chk("tx_gap", a.gap, 1);
    repeat (2) @(negedge app_clk);
    chk("tx_ready_back", tx_ready, 1);

    // TX full backpressure with poll gap 4
    cfg_poll_gap = 8'd4; sts_val = 8'h03;
    send_byte(8'h11);
    rd_ptr = bus_log.size();
    next_acc("full_skip0", a);
    next_acc("full_skip1", a);
    for (int i = 0; i < 3; i++) begin
      next_acc("full_poll", a);
      chk("full_poll_addr", {a.wr, a.addr}, {1'b0, 4'h1});
      chk("full_poll_gap", a.gap, 6);
    end
    sts_val = 8'h02;
    found = 0;
    for (int i = 0; i < 4 && !found; i++) begin
      next_acc("full_rel", a);
      if (a.wr) found = 1;
    end
    chk("full_rel_found", found, 1);
    chk("full_rel_data", {a.addr, a.wdata}, {4'h2, 8'h11});

    // RX path, client stalled
    sts_val = 8'h00; rxd_val = 8'hC3; rx_ready = 1'b0;
    rd_ptr = bus_log.size();
    found = 0;
    for (int i = 0; i < 4 && !found; i++) begin
      next_acc("rx_rd", a);
      if (!a.wr && a.addr == 4'h3) found = 1;
    end
    chk("rx_rd_found", found, 1);
    repeat (2) @(negedge app_clk);
    chk("rx_valid", rx_valid, 1);
    chk("rx_data", rx_data, 8'hC3);
    for (int i = 0; i < 3; i++) begin
      next_acc("rx_stall", a);
      chk("rx_stall_addr", {a.wr, a.addr}, {1'b0, 4'h1});
    end
    chk("rx_data_hold", rx_data, 8'hC3);
    rx_ready = 1'b1;
    @(negedge app_clk);
    rx_ready = 1'b0;
    @(negedge app_clk);
    chk("rx_cleared", rx_valid, 0);

    // round robin under constant contention
    cfg_enable = 1'b0;
    wait_idle();
    cfg_poll_gap = 8'd0; sts_val = 8'h00; rxd_val = 8'h3C;
    rx_ready = 1'b1; tx_valid = 1'b1; tx_data = 8'h77;
    repeat (3) @(negedge app_clk);
    rd_ptr = bus_log.size();
    cfg_enable = 1'b1;
    exp_pri = 0; n = 0;
    for (int i = 0; i < 16 && n < 4; i++) begin
      next_acc("rr_acc", a);
      if (a.addr != 4'h1) begin
        chk("rr_order", a.addr, exp_pri ? 4'h3 : 4'h2);
        exp_pri = 1 - exp_pri;
        n++;
      end
    end
    chk("rr_grants", n, 4);
    cfg_enable = 1'b0; tx_valid = 1'b0; rx_ready = 1'b0;
    wait_idle();
    rx_ready = 1'b1;
    repeat (2) @(negedge app_clk);
    rx_ready = 1'b0;

    // ack timeout on a status read
    no_ack = 1; sts_val = 8'h02;
    t0 = tmo_cnt;
    rd_ptr = bus_log.size();
    cfg_enable = 1'b1;
    next_acc("tmo_acc", a);
    chk("tmo_unacked", a.acked, 0);
    chk("tmo_len", a.len, 255);
    chk("tmo_addr", a.addr, 4'h1);
    chk("tmo_pulses", tmo_cnt - t0, 1);
    no_ack = 0;
    next_acc("tmo_repoll", a);
    chk("tmo_repoll_addr", {a.wr, a.addr, 3'(a.acked)}, {1'b0, 4'h1, 3'd1});
    cfg_enable = 1'b0;
    wait_idle();

    // reset in the middle of a TXD write
    ack_dly = 30; sts_val = 8'h02;
    if (tx_ready) send_byte(8'h99);
    cfg_enable = 1'b1;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge app_clk);
      if (reg_cs && reg_wr) found = 1;
    end
    chk("mid_wr_seen", found, 1);
    arst = 1'b1;
    #1;
    chk("mid_rst_cs", reg_cs, 0);
    chk("mid_rst_tx_ready", tx_ready, 0);
    chk("mid_rst_busy", busy, 0);
    cfg_enable = 1'b0;
    @(negedge app_clk);
    chk("mid_rst_tx_ready2", tx_ready, 0);
    arst = 1'b0;
    @(negedge app_clk);
    chk("mid_rel_tx_ready", tx_ready, 1);
    chk("mid_rel_busy", busy, 0);
    ack_dly = 1;

    // random traffic against the UART model
    s_log.delete();
    cfg_poll_gap = 8'($urandom_range(0, 3));
    rx_target = 20;
    mode = 1;
    cfg_enable = 1'b1;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge app_clk);
          send_byte(8'($urandom));
        end
      end
      begin
        held = 0; pd = 8'h00; n = 0;
        while (got_log.size() < 20 && n < 20000) begin
          @(negedge app_clk);
          n++;
          if (held && rx_valid && rx_data !== pd) rx_unstable++;
          rx_ready = ($urandom_range(0, 2) != 0);
          if (rx_valid && rx_ready) begin
            rbyte = rx_data;
            got_log.push_back(rbyte);
            held = 0;
          end else begin
            held = rx_valid;
            pd   = rx_data;
          end
        end
        rx_ready = 1'b0;
      end
    join
    n = 0;
    while (mtx_log.size() < 20 && n < 3000) begin
      @(negedge app_clk);
      n++;
    end
    chk("rnd_tx_count", mtx_log.size(), 20);
    chk("rnd_rx_count", got_log.size(), 20);
    for (int i = 0; i < 20; i++) begin
      if (i < mtx_log.size() && i < s_log.size()) chk("rnd_tx_byte", mtx_log[i], s_log[i]);
      if (i < got_log.size() && i < rxgen_log.size()) chk("rnd_rx_byte", got_log[i], rxgen_log[i]);
    end
    chk("rnd_model_err", model_err, 0);
    chk("rx_stable", rx_unstable, 0);
    chk("bus_stable", stab_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
